pong_ball_ctrl: RTL and testbench

//   Ball physics and scoring for Pong. Sits upstream of the VGA top level: consumes the
//   per-frame timing_tick and both paddle positions; produces ball top-left x_ball/y_ball
//   for draw_ball_pads and scores for draw_score. One position update per video frame.

---
 rtl/pong_ball_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: per-frame ball motion, wall/paddle bounce, goals and scoring.
// Optional macro BALL_SPEEDUP_EN: each paddle hit adds 1 to |dx| up to MAX_SPEED.
// Ports:
//   clk, rst (async, active-low), timing_tick (1/frame), start (level)
//   y_pad_left/right [9:0] : paddle top y
//   x_ball/y_ball [10:0]   : ball top-left (registered)
//   score_left/right [3:0] : saturating scores
//   goal_left/right        : 1-cycle scoring pulses
module pong_ball_ctrl #(
  parameter int H_RES       = 1024,
  parameter int V_RES       = 768,
  parameter int BALL_SIZE   = 16,
  parameter int PAD_W       = 16,
  parameter int PAD_H       = 96,
  parameter int PAD_X_LEFT  = 32,
  parameter int PAD_X_RIGHT = 976,
  parameter int SPEED_X     = 4,
  parameter int SPEED_Y     = 3,
  parameter int MAX_SPEED   = 12,
  parameter int SERVE_DELAY = 60,
  parameter int MAX_SCORE   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        goal_left,
  output logic        goal_right
);

  typedef enum logic [1:0] {
    IDLE, PLAY, SERVE, OVER
  } state_t;

  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic signed [11:0] X_C =
    12'((H_RES - BALL_SIZE) / 2);
  localparam logic signed [11:0] Y_C =
    12'((V_RES - BALL_SIZE) / 2);
  localparam logic signed [11:0] X_MAX =
    12'(H_RES - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX =
    12'(V_RES - BALL_SIZE);
  localparam logic signed [11:0] L_TH =
    12'(PAD_X_LEFT + PAD_W);
  localparam logic signed [11:0] R_TH =
    12'(PAD_X_RIGHT - BALL_SIZE);
  localparam logic signed [11:0] SPD_X =
    12'(SPEED_X);
  localparam logic signed [11:0] SPD_Y =
    12'(SPEED_Y);
  localparam logic signed [11:0] MAX_SPD =
    12'(MAX_SPEED);
  localparam logic [11:0] BS_U  = 12'(BALL_SIZE);
  localparam logic [11:0] PH_U  = 12'(PAD_H);
  localparam logic [3:0]  MAX_S = 4'(MAX_SCORE);

  state_t             state;
  logic signed [11:0] dx, dy;
  logic [CW-1:0]      cnt;

  logic signed [11:0] xs, ys, nx, ny;
  logic signed [11:0] mag_hit;
  logic [11:0]        yb, pl, pr;
  logic               ov_l, ov_r;
  logic               hit_l, hit_r;
  logic               miss_l, miss_r;
  logic [3:0]         sl_nx, sr_nx;

  assign xs = $signed({1'b0, x_ball});
  assign ys = $signed({1'b0, y_ball});
  assign nx = xs + dx;
  assign ny = ys + dy;

  assign yb = {1'b0, y_ball};
  assign pl = {2'b0, y_pad_left};
  assign pr = {2'b0, y_pad_right};

  // vertical overlap uses the pre-move y
  assign ov_l = (yb + BS_U > pl) && (yb < pl + PH_U);
  assign ov_r = (yb + BS_U > pr) && (yb < pr + PH_U);

  assign hit_l = dx[11] && (xs >= L_TH) &&
                 (nx < L_TH) && ov_l;
  assign hit_r = !dx[11] && (xs <= R_TH) &&
                 (nx > R_TH) && ov_r;

  assign miss_l = (nx <= 12'sd0);
  assign miss_r = (nx >= X_MAX);

`ifdef BALL_SPEEDUP_EN
  logic signed [11:0] mag;
  assign mag     = dx[11] ? -dx : dx;
  assign mag_hit = (mag >= MAX_SPD) ? MAX_SPD
                                    : mag + 12'sd1;
`else
  // serve speed never exceeds the ceiling
  assign mag_hit = (SPD_X > MAX_SPD) ? MAX_SPD
                                     : SPD_X;
`endif

  assign sl_nx = (score_left >= MAX_S) ? MAX_S
                                       : score_left + 4'd1;
  assign sr_nx = (score_right >= MAX_S) ? MAX_S
                                        : score_right + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      x_ball      <= X_C[10:0];
      y_ball      <= Y_C[10:0];
      dx          <= SPD_X;
      dy          <= SPD_Y;
      score_left  <= '0;
      score_right <= '0;
      goal_left   <= 1'b0;
      goal_right  <= 1'b0;
      cnt         <= '0;
    end else begin
      goal_left  <= 1'b0;
      goal_right <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) state <= PLAY;
        end
        PLAY: begin
          if (timing_tick) begin
            if (miss_l || miss_r) begin
              // goal beats any wall event on this tick
              x_ball <= X_C[10:0];
              y_ball <= Y_C[10:0];
              dy     <= SPD_Y;
              cnt    <= '0;
              if (miss_l) begin
                dx          <= -SPD_X;
                goal_right  <= 1'b1;
                score_right <= sr_nx;
                state <= (sr_nx == MAX_S) ? OVER : SERVE;
              end else begin
                dx         <= SPD_X;
                goal_left  <= 1'b1;
                score_left <= sl_nx;
                state <= (sl_nx == MAX_S) ? OVER : SERVE;
              end
            end else begin
              if (hit_l) begin
                x_ball <= L_TH[10:0];
                dx     <= mag_hit;
              end else if (hit_r) begin
                x_ball <= R_TH[10:0];
                dx     <= -mag_hit;
              end else begin
                x_ball <= nx[10:0];
              end
              if (ny <= 12'sd0) begin
                y_ball <= '0;
                dy     <= SPD_Y;
              end else if (ny >= Y_MAX) begin
                y_ball <= Y_MAX[10:0];
                dy     <= -SPD_Y;
              end else begin
                y_ball <= ny[10:0];
              end
            end
          end
        end
        SERVE: begin
          if (timing_tick) begin
            if (cnt == CW'(SERVE_DELAY - 1)) begin
              cnt   <= '0;
              state <= PLAY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OVER: begin
          if (start) begin
            state       <= PLAY;
            score_left  <= '0;
            score_right <= '0;
            x_ball      <= X_C[10:0];
            y_ball      <= Y_C[10:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed bench, MAX_SCORE=2, default (no speedup) build.
// Ball trajectory expectations are hand-derived from the chosen paddle moves.
module tb_pong_ball_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic        start;
  logic [9:0]  y_pad_left;
  logic [9:0]  y_pad_right;
  logic [10:0] x_ball;
  logic [10:0] y_ball;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        goal_left;
  logic        goal_right;

  int passed = 0;
  int total  = 0;
  int gl_cnt = 0;
  int gr_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (goal_left)  gl_cnt++;
    if (goal_right) gr_cnt++;
  end

  pong_ball_ctrl #(.MAX_SCORE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .start       (start),
    .y_pad_left  (y_pad_left),
    .y_pad_right (y_pad_right),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .score_left  (score_left),
    .score_right (score_right),
    .goal_left   (goal_left),
    .goal_right  (goal_right)
  );

  // one tick pulse followed by one idle cycle
  task automatic ticks(input int n);
    repeat (n) begin
      timing_tick = 1'b1;
      @(posedge clk); #1;
      timing_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_xy(input string nm,
                        input int ex, input int ey);
    total++;
    if (x_ball !== 11'(ex) || y_ball !== 11'(ey))
      $display("FAIL %s: got x=%0d y=%0d want x=%0d y=%0d",
               nm, x_ball, y_ball, ex, ey);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; timing_tick = 1'b0;
    y_pad_left = 10'd80; y_pad_right = 10'd700;
    repeat (3) begin
      timing_tick = 1'b1;
      @(posedge clk); #1;
    end
    timing_tick = 1'b0;
    chk_xy("in_reset", 504, 376);
    rst = 1'b1;
    ticks(10);
    chk_xy("idle_10_ticks", 504, 376);
    total++;
    if (score_left !== 4'd0 || score_right !== 4'd0)
      $display("FAIL reset_scores: got %0d/%0d want 0/0",
               score_left, score_right);
    else passed++;
    total++;
    if (gl_cnt + gr_cnt !== 0)
      $display("FAIL reset_goals: got %0d pulses want 0",
               gl_cnt + gr_cnt);
    else passed++;
  endtask

  task automatic test_first_move;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_xy("start_no_move", 504, 376);
    timing_tick = 1'b1;
    @(posedge clk); #1;
    timing_tick = 1'b0;
    chk_xy("first_tick", 508, 379);
    repeat (3) @(posedge clk);
    #1;
    chk_xy("hold_between_ticks", 508, 379);
  endtask

  task automatic test_right_pad;
    ticks(113);
    chk_xy("right_approach", 960, 718);
    ticks(1);
    chk_xy("right_bounce", 960, 721);
    ticks(1);
    chk_xy("right_after", 956, 724);
    y_pad_right = 10'd560;
  endtask

  task automatic test_wall_bottom;
    ticks(9);
    chk_xy("bottom_approach", 920, 751);
    ticks(1);
    chk_xy("bottom_clamp", 916, 752);
    ticks(1);
    chk_xy("bottom_flip", 912, 749);
  endtask

  task automatic test_left_pad;
    ticks(216);
    chk_xy("left_approach", 48, 101);
    ticks(1);
    chk_xy("left_bounce", 48, 98);
    ticks(1);
    chk_xy("left_after", 52, 95);
    y_pad_left = 10'd672;
  endtask

  task automatic test_wall_top;
    ticks(31);
    chk_xy("top_approach", 176, 2);
    ticks(1);
    chk_xy("top_clamp", 180, 0);
    ticks(1);
    chk_xy("top_flip", 184, 3);
    ticks(195);
    chk_xy("right_bounce2", 960, 588);
  endtask

  task automatic test_goal;
    ticks(239);
    chk_xy("goal_approach", 4, 200);
    timing_tick = 1'b1;
    @(posedge clk); #1;
    timing_tick = 1'b0;
    total++;
    if (goal_right !== 1'b1 || goal_left !== 1'b0)
      $display("FAIL goal_pulse: got r=%0b l=%0b want r=1 l=0",
               goal_right, goal_left);
    else passed++;
    total++;
    if (score_right !== 4'd1 || score_left !== 4'd0)
      $display("FAIL goal_score: got r=%0d l=%0d want r=1 l=0",
               score_right, score_left);
    else passed++;
    chk_xy("goal_recentre", 504, 376);
    @(posedge clk); #1;
    total++;
    if (goal_right !== 1'b0)
      $display("FAIL goal_pulse_len: got %0b want 0", goal_right);
    else passed++;
    ticks(59);
    chk_xy("serve_hold_59", 504, 376);
    ticks(1);
    chk_xy("serve_hold_60", 504, 376);
    ticks(1);
    chk_xy("serve_move_left", 500, 379);
    total++;
    if (gr_cnt !== 1 || gl_cnt !== 0)
      $display("FAIL goal_count: got r=%0d l=%0d want r=1 l=0",
               gr_cnt, gl_cnt);
    else passed++;
  endtask

  task automatic test_game_over;
    y_pad_left = 10'd0;
    ticks(124);
    chk_xy("over_approach", 4, 751);
    timing_tick = 1'b1;
    @(posedge clk); #1;
    timing_tick = 1'b0;
    total++;
    if (goal_right !== 1'b1 || score_right !== 4'd2)
      $display("FAIL wall_goal: got pulse=%0b score=%0d want 1/2",
               goal_right, score_right);
    else passed++;
    chk_xy("goal_beats_wall", 504, 376);
    ticks(5);
    chk_xy("over_frozen", 504, 376);
    total++;
    if (score_right !== 4'd2)
      $display("FAIL over_score: got %0d want 2", score_right);
    else passed++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (score_right !== 4'd0 || score_left !== 4'd0)
      $display("FAIL restart_scores: got r=%0d l=%0d want 0/0",
               score_right, score_left);
    else passed++;
    timing_tick = 1'b1;
    @(posedge clk); #1;
    timing_tick = 1'b0;
    chk_xy("restart_move", 500, 379);
  endtask

  task automatic test_reset_mid_play;
    ticks(2);
    chk_xy("pre_reset", 492, 385);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_xy("async_reset", 504, 376);
    total++;
    if (score_right !== 4'd0 || goal_right !== 1'b0)
      $display("FAIL async_reset_misc: got s=%0d g=%0b want 0/0",
               score_right, goal_right);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    ticks(3);
    chk_xy("idle_after_reset", 504, 376);
    total++;
    if (gr_cnt !== 2 || gl_cnt !== 0)
      $display("FAIL final_goals: got r=%0d l=%0d want r=2 l=0",
               gr_cnt, gl_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_right_pad();
    test_wall_bottom();
    test_left_pad();
    test_wall_top();
    test_goal();
    test_game_over();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
